line_buffer_ntaps: RTL

LINE_BUFFER_NTAPS -- requirements
Module: line_buffer_ntaps

---
 rtl/line_buffer_ntaps.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/line_buffer_ntaps.sv
// ---------------------------------------------------------------------------
// line_buffer_ntaps
//   Raster-order line buffer producing a vertical column window of TAPS+1
//   pixels: the current pixel plus the pixels at the same column on the TAPS
//   previous lines. TAPS line stores are cascaded: store 0 captures the
//   incoming pixel, and store k captures what store k-1 held for that column.
//   Each store does read-before-write at the current column, so its read
//   value is always exactly one line older than what it is being written.
//
// Parameters
//   DATA_WIDTH  pixel width in bits
//   IMG_WIDTH   pixels per line (2..4096), also the RAM depth
//   TAPS        number of stored past lines (1..8)
//
// Ports
//   clk           single clock
//   rst_n         async active-low reset (counters and outputs only, no RAM)
//   dat_in        input pixel
//   dat_in_valid  one pixel accepted per high cycle
//   sof           start of frame, only meaningful with dat_in_valid
//   taps_out      slice k = pixel k lines above, slice 0 = current pixel
//   taps_valid    one-cycle pulse when taps_out was updated
//   window_ready  every slice holds data from the current frame
//   col, row      position of the pixel on taps_out (row saturates)
// ---------------------------------------------------------------------------

// One line store: asynchronous read, synchronous write. Read-before-write
// falls out naturally because the read value is sampled at the same edge
// that commits the write.
module line_buffer_ntaps_store #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 400,
  parameter int AW         = $clog2(IMG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

  assign rd_data = mem[addr];

  // No reset: stale contents are masked downstream by window_ready.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

module line_buffer_ntaps #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 400,
  parameter int TAPS       = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          dat_in,
  input  logic                           dat_in_valid,
  input  logic                           sof,
  output logic [(TAPS+1)*DATA_WIDTH-1:0] taps_out,
  output logic                           taps_valid,
  output logic                           window_ready,
  output logic [$clog2(IMG_WIDTH)-1:0]   col,
  output logic [15:0]                    row
);

  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int FW     = $clog2(TAPS+1);
  localparam int STAGES = 1;

  // Position of a beat within the frame.
  typedef struct packed {
    logic [CW-1:0] col;
    logic [15:0]   row;
    logic [FW-1:0] fill;
  } pos_t;

  pos_t wr_pos;  // position the next accepted beat takes unless sof
  pos_t cur;     // position of the beat being accepted this cycle
  pos_t nxt;     // position after this beat
  logic last_col;

  logic [STAGES:0] vld_pipe;

  logic [TAPS-1:0][DATA_WIDTH-1:0] rd_data;
  logic [TAPS-1:0][DATA_WIDTH-1:0] wr_data;
  logic [TAPS:0][DATA_WIDTH-1:0]   taps_q;

  assign vld_pipe[0] = dat_in_valid;

  // sof forces the beat to column 0, row 0 and an empty window, whatever the
  // counters say; a partially filled line is simply abandoned.
  assign cur      = sof ? '0 : wr_pos;
  assign last_col = (cur.col == CW'(IMG_WIDTH-1));

  always_comb begin
    nxt = cur;
    if (last_col) begin
      nxt.col = '0;
      if (cur.row != 16'hFFFF)   nxt.row  = cur.row + 16'd1;
      if (cur.fill != FW'(TAPS)) nxt.fill = cur.fill + FW'(1);
    end else begin
      nxt.col = cur.col + CW'(1);
    end
  end

  // Cascaded stores: store 0 takes the new pixel, store k takes the
  // one-line-old value just read out of store k-1 at the same column.
  for (genvar k = 0; k < TAPS; k++) begin : g_store
    if (k == 0) begin : g_head
      assign wr_data[k] = dat_in;
    end else begin : g_tail
      assign wr_data[k] = rd_data[k-1];
    end

    line_buffer_ntaps_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMG_WIDTH  (IMG_WIDTH),
      .AW         (CW)
    ) u_store (
      .clk     (clk),
      .we      (vld_pipe[0]),
      .addr    (cur.col),
      .wr_data (wr_data[k]),
      .rd_data (rd_data[k])
    );
  end

  // Counters and output registers. Everything except the valid pulse is held
  // when no beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pos       <= '0;
      taps_q       <= '0;
      col          <= '0;
      row          <= '0;
      window_ready <= 1'b0;
      vld_pipe[1]  <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        wr_pos         <= nxt;
        taps_q[0]      <= dat_in;
        taps_q[TAPS:1] <= rd_data;
        col            <= cur.col;
        row            <= cur.row;
        window_ready   <= (cur.fill == FW'(TAPS));
      end
    end
  end

  assign taps_out   = taps_q;
  assign taps_valid = vld_pipe[STAGES];

endmodule
